// File: rtl/pll_pkg.sv
// Shared types and constants for the Tiny-PLL phase-detect path.
package pll_pkg;
  typedef enum logic [1:0] {IDLE, LEAD_REF, LEAD_FB} pfd_state_t;

  localparam int ERR_W_DEF = 16;

  // Largest magnitude a w-bit signed error may take; kept symmetric so negation never overflows.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a registered-previous rising-edge detect.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/pfd_counter.sv
// Counter-based phase-frequency detector: UP/DN pulses, signed phase error and lock flag,
// all in the clk_in domain.
module pfd_counter
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = ERR_W_DEF,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 8
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    ref_in,
  input  logic                    fb_in,
  input  logic                    enable,
  output logic                    up,
  output logic                    dn,
  output logic                    err_valid,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    locked
);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic signed [ERR_W-1:0] SAT     = ERR_W'(sat_max(ERR_W));
  localparam logic signed [ERR_W-1:0] TOL     = ERR_W'(LOCK_TOL);
  localparam logic        [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  logic w_ref_rise, w_fb_rise, w_close, w_other;
  logic signed [ERR_W-1:0] w_err;

  pfd_state_t              r_state;
  logic signed [ERR_W-1:0] r_cnt;
  logic [RUN_W-1:0]        r_run;
  logic                    r_up, r_dn, r_ev, r_locked;
  logic signed [ERR_W-1:0] r_phase;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk_in(clk_in), .rst(rst), .din(ref_in), .rise(w_ref_rise)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk_in(clk_in), .rst(rst), .din(fb_in), .rise(w_fb_rise)
  );

  // The "closing" edge is whichever input did not open the current measurement.
  assign w_close = (r_state == LEAD_REF) ? w_fb_rise  : w_ref_rise;
  assign w_other = (r_state == LEAD_REF) ? w_ref_rise : w_fb_rise;
  assign w_err   = (r_state == LEAD_REF) ? r_cnt : -r_cnt;

  function automatic logic [RUN_W-1:0] run_next(input logic signed [ERR_W-1:0] e,
                                                input logic [RUN_W-1:0] run);
    logic signed [ERR_W-1:0] a;
    a = (e < 0) ? -e : e;
    if (a > TOL)           return '0;
    else if (run == RUN_MAX) return run;
    else                   return run + RUN_W'(1);
  endfunction

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_run    <= '0;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_ev     <= 1'b0;
      r_locked <= 1'b0;
      r_phase  <= '0;
    end else if (!enable) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_run    <= '0;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_ev     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_ev     <= 1'b0;
      r_locked <= (r_run == RUN_MAX);
      case (r_state)
        IDLE: begin
          if (w_ref_rise && w_fb_rise) begin
            r_ev    <= 1'b1;
            r_phase <= '0;
            r_run   <= run_next('0, r_run);
          end else if (w_ref_rise) begin
            r_state <= LEAD_REF;
            r_cnt   <= ERR_W'(1);
            r_up    <= 1'b1;
          end else if (w_fb_rise) begin
            r_state <= LEAD_FB;
            r_cnt   <= ERR_W'(1);
            r_dn    <= 1'b1;
          end
        end
        LEAD_REF, LEAD_FB: begin
          if (w_close) begin
            r_ev    <= 1'b1;
            r_phase <= w_err;
            r_run   <= run_next(w_err, r_run);
            if (w_other) begin
              r_cnt <= ERR_W'(1);
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_up    <= 1'b0;
              r_dn    <= 1'b0;
            end
          end else if (r_cnt == SAT) begin
            // A pinned counter means the loop is far off frequency: drop lock.
            r_run    <= '0;
            r_locked <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ERR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up        = r_up;
  assign dn        = r_dn;
  assign err_valid = r_ev;
  assign phase_err = r_phase;
  assign locked    = r_locked;
endmodule

// File: tb/tb_pfd_counter.sv
// Randomized scoreboard bench for pfd_counter; runs a 16-bit and an 8-bit instance side by side.
module tb_pfd_counter;
  localparam int SYNC = 2, TOL = 2, LC = 8;

  logic clk = 1'b0, rst = 1'b1, ref_i = 1'b0, fb_i = 1'b0, en = 1'b0;
  logic up_a, dn_a, ev_a, lk_a;
  logic [15:0] pe_a;
  logic up_b, dn_b, ev_b, lk_b;
  logic [7:0] pe_b;

  int checks = 0, failures = 0;

  typedef struct {logic up, dn, ev, lk; int ph;} exp_t;
  exp_t qa[$], qb[$];
  int   ea[$], eb[$];

  // Reference model: timestamps of the leading edge rather than a cycle counter.
  int   lead[2], tl[2], run[2], lkd[2], ph[2];
  logic evd[2];
  int   satv[2] = '{32767, 127};
  logic hr[SYNC+1], hf[SYNC+1];
  int   n = 0;
  logic en_cur = 1'b1;

  pfd_counter #(.SYNC_STAGES(SYNC), .ERR_W(16), .LOCK_TOL(TOL), .LOCK_CNT(LC)) u_dut16 (
    .clk_in(clk), .rst(rst), .ref_in(ref_i), .fb_in(fb_i), .enable(en),
    .up(up_a), .dn(dn_a), .err_valid(ev_a), .phase_err(pe_a), .locked(lk_a)
  );
  pfd_counter #(.SYNC_STAGES(SYNC), .ERR_W(8), .LOCK_TOL(TOL), .LOCK_CNT(LC)) u_dut8 (
    .clk_in(clk), .rst(rst), .ref_in(ref_i), .fb_in(fb_i), .enable(en),
    .up(up_b), .dn(dn_b), .err_valid(ev_b), .phase_err(pe_b), .locked(lk_b)
  );

  always #5 clk = ~clk;

  function automatic void mdl_err(input int d, input int e);
    int a;
    a = (e < 0) ? -e : e;
    evd[d] = 1'b1;
    ph[d]  = e;
    run[d] = (a <= TOL) ? ((run[d] + 1 > LC) ? LC : run[d] + 1) : 0;
    if (d == 0) ea.push_back(e); else eb.push_back(e);
  endfunction

  function automatic void model(input logic r, input logic f, input logic e, input logic x);
    logic rr, fr, cl, ot;
    int   mag, nl;
    exp_t ex;
    n++;
    for (int d = 0; d < 2; d++) evd[d] = 1'b0;
    if (x) begin
      for (int i = 0; i <= SYNC; i++) begin hr[i] = 1'b0; hf[i] = 1'b0; end
      for (int d = 0; d < 2; d++) begin lead[d] = 0; run[d] = 0; lkd[d] = 0; ph[d] = 0; end
    end else begin
      rr = hr[SYNC-1] & ~hr[SYNC];
      fr = hf[SYNC-1] & ~hf[SYNC];
      for (int i = SYNC; i > 0; i--) begin hr[i] = hr[i-1]; hf[i] = hf[i-1]; end
      hr[0] = r;
      hf[0] = f;
      for (int d = 0; d < 2; d++) begin
        if (!e) begin
          lead[d] = 0; run[d] = 0; lkd[d] = 0;
        end else begin
          nl = (run[d] == LC) ? 1 : 0;
          if (lead[d] == 0) begin
            if (rr && fr) mdl_err(d, 0);
            else if (rr) begin lead[d] = 1; tl[d] = n; end
            else if (fr) begin lead[d] = 2; tl[d] = n; end
          end else begin
            cl = (lead[d] == 1) ? fr : rr;
            ot = (lead[d] == 1) ? rr : fr;
            if (cl) begin
              mag = (n - tl[d] > satv[d]) ? satv[d] : n - tl[d];
              mdl_err(d, (lead[d] == 1) ? mag : -mag);
              if (ot) tl[d] = n; else lead[d] = 0;
            end else if (n - tl[d] >= satv[d]) begin
              run[d] = 0;
              nl = 0;
            end
          end
          lkd[d] = nl;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      ex.up = (lead[d] == 1);
      ex.dn = (lead[d] == 2);
      ex.ev = evd[d];
      ex.lk = (lkd[d] != 0);
      ex.ph = ph[d];
      if (d == 0) qa.push_back(ex); else qb.push_back(ex);
    end
  endfunction

  function automatic void cmp(input string nm, input logic [3:0] act, input logic [3:0] exv,
                              input logic [15:0] pa, input logic [15:0] px);
    checks++;
    if (act !== exv || pa !== px) begin
      failures++;
      $display("FAIL %s cyc=%0d: up/dn/ev/lk=%b phase=%h, expected %b phase=%h",
               nm, n, act, pa, exv, px);
    end
  endfunction

  // Monitor: per-cycle output check plus error-value scoreboard popped on each err_valid.
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("out16", {up_a, dn_a, ev_a, lk_a}, {e.up, e.dn, e.ev, e.lk}, pe_a, 16'(e.ph));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("out8", {up_b, dn_b, ev_b, lk_b}, {e.up, e.dn, e.ev, e.lk}, {8'h0, pe_b}, {8'h0, 8'(e.ph)});
    end
    if (ev_a) begin
      checks++;
      if (ea.size() == 0) begin
        failures++;
        $display("FAIL err16 unexpected err_valid phase=%h", pe_a);
      end else begin
        v = ea.pop_front();
        if (pe_a !== 16'(v)) begin
          failures++;
          $display("FAIL err16 phase=%h expected %h", pe_a, 16'(v));
        end
      end
    end
    if (ev_b) begin
      checks++;
      if (eb.size() == 0) begin
        failures++;
        $display("FAIL err8 unexpected err_valid phase=%h", pe_b);
      end else begin
        v = eb.pop_front();
        if (pe_b !== 8'(v)) begin
          failures++;
          $display("FAIL err8 phase=%h expected %h", pe_b, 8'(v));
        end
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic e, input logic x);
    ref_i = r; fb_i = f; en = e; rst = x;
    @(posedge clk);
    model(r, f, e, x);
    @(negedge clk);
    #1;
  endtask

  task automatic pair(input int off, input int hold);
    int rs, fs, len;
    rs  = (off < 0) ? -off : 0;
    fs  = (off > 0) ? off : 0;
    len = ((rs > fs) ? rs : fs) + hold;
    for (int i = 0; i < len; i++) step(i >= rs, i >= fs, en_cur, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, en_cur, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    #1;
    cmp("rst16", {up_a, dn_a, ev_a, lk_a}, 4'b0, pe_a, 16'h0);
    cmp("rst8",  {up_b, dn_b, ev_b, lk_b}, 4'b0, {8'h0, pe_b}, 16'h0);
    for (int i = 0; i < cyc; i++) step(1'(i % 2), 1'((i + 1) % 2), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int k, off;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    pair(5, 3);
    pair(-3, 3);
    repeat (8) pair(0, 3);
    pair(10, 3);
    // ref toggling with fb stuck low: the 8-bit instance saturates at 127
    for (int i = 0; i < 300; i++) step(1'(((i / 4) % 2) == 1), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    // disable during LEAD_FB, then re-enable with static inputs
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    // reset in the middle of LEAD_REF
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(4);
    for (int it = 0; it < 150; it++) begin
      k = int'($urandom_range(0, 99));
      if (k < 3) do_reset(2);
      en_cur = ($urandom_range(0, 9) != 0);
      if (k >= 90 && k < 96) begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, en_cur, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, en_cur, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, en_cur, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, en_cur, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, en_cur, 1'b0);
      end else begin
        off = (k < 50) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 40)) - 20;
        pair(off, int'($urandom_range(1, 5)));
      end
    end
    en_cur = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ea.size() != 0 || eb.size() != 0) begin
      failures++;
      $display("FAIL missing_err pending16=%0d pending8=%0d expected 0", ea.size(), eb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
